// File: rtl/overlay_pkg.sv
// Shared types and default timing constants for the overlay fetch scheduler.
package overlay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    // 1080p60 raster defaults
    localparam int unsigned H_ACTIVE_1080P  = 1920;
    localparam int unsigned V_ACTIVE_1080P  = 1080;
    localparam int unsigned H_TOTAL_1080P   = 2200;
    localparam int unsigned V_TOTAL_1080P   = 1125;

    localparam int unsigned PIXEL_WIDTH_DEF = 24;
    localparam int unsigned ADDR_WIDTH_DEF  = 20;
    localparam int unsigned POS_WIDTH       = 12;

endpackage

// File: rtl/overlay_line_fifo.sv
// Synchronous show-ahead FIFO holding prefetched overlay pixels; flush empties it in one clock.
module overlay_line_fifo #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 24
) (
    input  logic                     pixelClock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic [DATA_W-1:0]        head_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              empty_q;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge pixelClock) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset; pointers define validity
    always_ff @(posedge pixelClock) begin
        if (do_push && !reset && !flush) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    assign count  = count_q;
    assign empty  = empty_q;
    assign head_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/overlay_fetch_scheduler.sv
// Prefetches overlay pixels in bursts and streams them in step with DE/VSYNC.
// Optional macro OVL_CHROMA_KEY_EN adds keyColor transparency on popped pixels.
module overlay_fetch_scheduler
    import overlay_pkg::*;
#(
    parameter int unsigned width      = H_ACTIVE_1080P,
    parameter int unsigned height     = V_ACTIVE_1080P,
    parameter int unsigned ovlX       = 0,
    parameter int unsigned ovlY       = 0,
    parameter int unsigned ovlWidth   = 640,
    parameter int unsigned ovlHeight  = 480,
    parameter int unsigned baseAddr   = 0,
    parameter int unsigned burstLen   = 16,
    parameter int unsigned fifoDepth  = 64,
    parameter int unsigned addrWidth  = ADDR_WIDTH_DEF,
    parameter int unsigned pixelWidth = PIXEL_WIDTH_DEF
`ifdef OVL_CHROMA_KEY_EN
    ,
    parameter logic [pixelWidth-1:0] keyColor = pixelWidth'(24'h00FF00)
`endif
) (
    input  logic                  pixelClock,
    input  logic                  reset,
    input  logic                  DE,
    input  logic                  VSYNC,
    output logic                  memReq,
    output logic [addrWidth-1:0]  memAddr,
    input  logic                  memGnt,
    input  logic                  memDataValid,
    input  logic [pixelWidth-1:0] memData,
    output logic                  ovlValid,
    output logic [pixelWidth-1:0] ovlPixel,
    output logic                  underflow
);

    localparam int unsigned POS_W  = POS_WIDTH;
    localparam int unsigned CNT_W  = $clog2(fifoDepth) + 1;
    localparam int unsigned BEAT_W = $clog2(burstLen) + 1;

    localparam logic [POS_W-1:0]     Y_MAX     = POS_W'(height);
    localparam logic [addrWidth-1:0] TOTAL     = addrWidth'(ovlWidth * ovlHeight);
    localparam logic [addrWidth-1:0] BURST     = addrWidth'(burstLen);
    localparam logic [addrWidth-1:0] BASE      = addrWidth'(baseAddr);
    localparam logic [CNT_W-1:0]     ROOM      = CNT_W'(fifoDepth - burstLen);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(burstLen - 1);

    logic                  vsync_q;
    logic                  de_q;
    logic                  synced_q;
    logic [POS_W-1:0]      x_pos_q;
    logic [POS_W-1:0]      y_pos_q;
    logic                  vsync_rise_c;
    logic [POS_W:0]        rel_x_c;
    logic [POS_W:0]        rel_y_c;
    logic                  in_win_c;

    fetch_state_e          state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [addrWidth-1:0]  mem_addr_q, mem_addr_d;
    logic [addrWidth-1:0]  fetched_q, fetched_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  abort_q, abort_d;
    logic                  fifo_push_c;

    logic                  fifo_pop_c;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic [pixelWidth-1:0] fifo_head_c;
    logic                  key_hit_c;

    logic                  ovl_valid_q;
    logic [pixelWidth-1:0] ovl_pixel_q;
    logic                  underflow_q;

    assign vsync_rise_c = VSYNC && !vsync_q;

    // Raster position tracking
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            vsync_q  <= 1'b0;
            de_q     <= 1'b0;
            synced_q <= 1'b0;
            x_pos_q  <= '0;
            y_pos_q  <= '0;
        end else begin
            vsync_q <= VSYNC;
            de_q    <= DE;
            if (vsync_rise_c) begin
                synced_q <= 1'b1;
                x_pos_q  <= '0;
                y_pos_q  <= '0;
            end else if (DE) begin
                x_pos_q <= x_pos_q + 1'b1;
            end else if (de_q) begin
                x_pos_q <= '0;
                if (y_pos_q != Y_MAX) begin
                    y_pos_q <= y_pos_q + 1'b1;
                end
            end
        end
    end

    // Offsets below the window wrap to large values, so one compare per axis suffices
    assign rel_x_c  = {1'b0, x_pos_q} - (POS_W + 1)'(ovlX);
    assign rel_y_c  = {1'b0, y_pos_q} - (POS_W + 1)'(ovlY);
    assign in_win_c = DE && (rel_x_c < (POS_W + 1)'(ovlWidth))
                         && (rel_y_c < (POS_W + 1)'(ovlHeight));

    assign fifo_pop_c = in_win_c && !fifo_empty;

    overlay_line_fifo #(
        .DEPTH  (fifoDepth),
        .DATA_W (pixelWidth)
    ) u_fifo (
        .pixelClock (pixelClock),
        .reset      (reset),
        .flush      (vsync_rise_c),
        .push       (fifo_push_c),
        .pop        (fifo_pop_c),
        .data       (memData),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .head_c     (fifo_head_c)
    );

`ifdef OVL_CHROMA_KEY_EN
    assign key_hit_c = (fifo_head_c == keyColor);
`else
    assign key_hit_c = 1'b0;
`endif

    // Pixel output stage and sticky underflow
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            ovl_valid_q <= 1'b0;
            ovl_pixel_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (fifo_pop_c) begin
                ovl_valid_q <= !key_hit_c;
                ovl_pixel_q <= fifo_head_c;
            end else if (in_win_c) begin
                ovl_valid_q <= 1'b0;
                ovl_pixel_q <= '0;
            end else begin
                ovl_valid_q <= 1'b0;
            end
            if (vsync_rise_c) begin
                underflow_q <= 1'b0;
            end else if (in_win_c && fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= BASE;
            fetched_q  <= '0;
            beat_q     <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetched_q  <= fetched_d;
            beat_q     <= beat_d;
            abort_q    <= abort_d;
        end
    end

    // Fetch FSM: one burst outstanding, FIFO space reserved before requesting
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fetched_d   = fetched_q;
        beat_d      = beat_q;
        abort_d     = abort_q;
        fifo_push_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (synced_q && !vsync_rise_c && (fetched_q < TOTAL) && (fifo_count <= ROOM)) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = BASE + fetched_q;
                end
            end
            REQ: begin
                if (vsync_rise_c) begin
                    abort_d = 1'b1;
                end
                if (memGnt) begin
                    mem_req_d = 1'b0;
                    beat_d    = '0;
                    abort_d   = 1'b0;
                    state_d   = (abort_q || vsync_rise_c) ? DRAIN : DATA;
                end
            end
            DATA: begin
                if (memDataValid) begin
                    beat_d      = beat_q + 1'b1;
                    fifo_push_c = !vsync_rise_c;
                    if (beat_q == LAST_BEAT) begin
                        state_d   = IDLE;
                        fetched_d = fetched_q + BURST;
                    end else if (vsync_rise_c) begin
                        state_d = DRAIN;
                    end
                end else if (vsync_rise_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (memDataValid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (vsync_rise_c) begin
            fetched_d = '0;
        end
    end

    assign memReq    = mem_req_q;
    assign memAddr   = mem_addr_q;
    assign ovlValid  = ovl_valid_q;
    assign ovlPixel  = ovl_pixel_q;
    assign underflow = underflow_q;

endmodule
